// File: rtl/id_stage_if.sv
// ID/EX <-> ALU control interface.
// The decode stage (master) presents the registered ALU operands, control
// code and writeback tags; the execution stage (slave) returns its
// acceptance and the combinational ALU result of the entry it is looking at.
interface id_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    logic [31:0] alu_result;

    modport master (
        output ex_valid, ex_a, ex_b, ex_ctrl, ex_rd, ex_we, ex_imm, ex_illegal,
        input  ex_ready, alu_result
    );

    modport slave (
        input  ex_valid, ex_a, ex_b, ex_ctrl, ex_rd, ex_we, ex_imm, ex_illegal,
        output ex_ready, alu_result
    );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode/issue stage of the in-order pipeline.
// Decodes one 32-bit instruction per cycle, reads two register-file ports,
// resolves operand hazards and loads the ID/EX register that drives the ALU.
// Optional feature macro: ID_FORWARD_EN
//   defined   -> EX/WB forwarding, stall only on an EX hit while EX is blocked
//   undefined -> no forwarding, stall on any EX or WB hit
module id_stage #(
    parameter logic [3:0] NOP_OPC = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    // fetch side
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    // register file read ports
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    // writeback stage
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    // branch resolution
    input  logic        flush,
    // ID/EX towards the ALU
    id_stage_if.master  ex
);

    // ALU control codes
    localparam logic [2:0] CTRL_ADD = 3'b000;
    localparam logic [2:0] CTRL_SUB = 3'b001;
    localparam logic [2:0] CTRL_SLT = 3'b010;
    localparam logic [2:0] CTRL_AND = 3'b011;
    localparam logic [2:0] CTRL_OR  = 3'b100;

    typedef struct packed {
        logic       issue;    // produces an ID/EX entry
        logic       illegal;  // undefined opcode
        logic [2:0] ctrl;     // ALU control code
        logic       b_imm;    // operand B is the sign-extended immediate
        logic       we;       // writes rd (before the r0 override)
        logic       use_rs2;  // rs2 is a real source operand
    } dec_t;

    // Opcode decode. The bubble opcode takes precedence so that NOP_OPC can
    // be moved onto any encoding without also flagging it illegal.
    function automatic dec_t decode(input logic [3:0] opc);
        dec_t d;
        d = '{issue: 1'b0, illegal: 1'b0, ctrl: CTRL_ADD,
              b_imm: 1'b0, we: 1'b0, use_rs2: 1'b0};
        if (opc == NOP_OPC) begin
            d.issue = 1'b0;
        end else begin
            case (opc)
                4'd1: d = '{1'b1, 1'b0, CTRL_ADD, 1'b0, 1'b1, 1'b1};
                4'd2: d = '{1'b1, 1'b0, CTRL_SUB, 1'b0, 1'b1, 1'b1};
                4'd3: d = '{1'b1, 1'b0, CTRL_AND, 1'b0, 1'b1, 1'b1};
                4'd4: d = '{1'b1, 1'b0, CTRL_OR,  1'b0, 1'b1, 1'b1};
                4'd5: d = '{1'b1, 1'b0, CTRL_ADD, 1'b1, 1'b1, 1'b0};
                4'd6: d = '{1'b1, 1'b0, CTRL_SLT, 1'b0, 1'b0, 1'b1};
                4'd0: d.issue = 1'b0;
                default: d.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    // Source operand value. r0 is hard-wired to zero ahead of any bypass.
    function automatic logic [31:0] sel_operand(
        input logic [4:0]  src,
        input logic        ex_hit,
        input logic        wb_hit,
        input logic [31:0] rf_val,
        input logic [31:0] alu_val,
        input logic [31:0] wb_val
    );
        logic [31:0] v;
        if (src == 5'd0) begin
            v = 32'd0;
        end else if (ex_hit) begin
            v = alu_val;
        end else if (wb_hit) begin
            v = wb_val;
        end else begin
            v = rf_val;
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [3:0]  opc_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm_s;
    dec_t        dec_s;

    assign opc_s     = if_instr[31:28];
    assign rd_s      = if_instr[27:23];
    assign rs1_s     = if_instr[22:18];
    assign rs2_s     = if_instr[17:13];
    assign imm_s     = {{19{if_instr[12]}}, if_instr[12:0]};
    assign dec_s     = decode(opc_s);

    // Register file addresses come straight from the instruction word.
    assign rf_raddr1 = rs1_s;
    assign rf_raddr2 = rs2_s;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic        ex_valid_q,   ex_valid_d;
    logic [31:0] ex_a_q,       ex_a_d;
    logic [31:0] ex_b_q,       ex_b_d;
    logic [2:0]  ex_ctrl_q,    ex_ctrl_d;
    logic [4:0]  ex_rd_q,      ex_rd_d;
    logic        ex_we_q,      ex_we_d;
    logic [31:0] ex_imm_q,     ex_imm_d;
    logic        ex_illegal_q, ex_illegal_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic use1_s, use2_s;
    logic ex_hit1_s, ex_hit2_s;
    logic wb_hit1_s, wb_hit2_s;
    logic advance_s, stall_s, accept_s;
    logic [31:0] op_a_s, op_b_s;

    // Only issuing instructions with a non-zero source register can collide.
    assign use1_s    = if_valid && dec_s.issue && (rs1_s != 5'd0);
    assign use2_s    = if_valid && dec_s.issue && dec_s.use_rs2 && (rs2_s != 5'd0);

    assign ex_hit1_s = use1_s && ex_valid_q && ex_we_q && (ex_rd_q == rs1_s);
    assign ex_hit2_s = use2_s && ex_valid_q && ex_we_q && (ex_rd_q == rs2_s);
    assign wb_hit1_s = use1_s && wb_we && (wb_rd == rs1_s);
    assign wb_hit2_s = use2_s && wb_we && (wb_rd == rs2_s);

    // The ID/EX slot is free when empty or when its entry leaves this cycle.
    assign advance_s = !ex_valid_q || ex.ex_ready;

`ifdef ID_FORWARD_EN
    // The ALU result is only valid to bypass while its entry moves on; if EX
    // is blocked the consumer must wait for it.
    assign stall_s = (ex_hit1_s || ex_hit2_s) && !ex.ex_ready;

    // Forwarded operands: EX result beats WB result beats the register file.
    always_comb begin
        op_a_s = sel_operand(rs1_s, ex_hit1_s, wb_hit1_s, rf_rdata1,
                             ex.alu_result, wb_result);
        if (dec_s.b_imm) begin
            op_b_s = imm_s;
        end else begin
            op_b_s = sel_operand(rs2_s, ex_hit2_s, wb_hit2_s, rf_rdata2,
                                 ex.alu_result, wb_result);
        end
    end
`else
    // Without bypass paths, any in-flight producer holds the consumer back
    // until the register file has been written.
    assign stall_s = ex_hit1_s || ex_hit2_s || wb_hit1_s || wb_hit2_s;

    // Register-file operands only; bypass inputs are intentionally idle.
    always_comb begin
        op_a_s = sel_operand(rs1_s, 1'b0, 1'b0, rf_rdata1, 32'd0, 32'd0);
        if (dec_s.b_imm) begin
            op_b_s = imm_s;
        end else begin
            op_b_s = sel_operand(rs2_s, 1'b0, 1'b0, rf_rdata2, 32'd0, 32'd0);
        end
    end

    logic unused_s;
    assign unused_s = ^{ex.alu_result, wb_result};
`endif

    // A flush always consumes the incoming word so fetch can redirect.
    assign if_ready = (advance_s && !stall_s) || flush;
    assign accept_s = if_valid && if_ready;

    // Next-state of the ID/EX register: flush > issue > drain > hold.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_rd_d      = ex_rd_q;
        ex_we_d      = ex_we_q;
        ex_imm_d     = ex_imm_q;
        ex_illegal_d = accept_s && dec_s.illegal && !flush;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept_s && dec_s.issue) begin
            ex_valid_d = 1'b1;
            ex_a_d     = op_a_s;
            ex_b_d     = op_b_s;
            ex_ctrl_d  = dec_s.ctrl;
            ex_rd_d    = rd_s;
            ex_we_d    = dec_s.we && (rd_s != 5'd0);
            ex_imm_d   = imm_s;
        end else if (advance_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX state with synchronous reset to an all-zero entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_a_q       <= 32'd0;
            ex_b_q       <= 32'd0;
            ex_ctrl_q    <= 3'd0;
            ex_rd_q      <= 5'd0;
            ex_we_q      <= 1'b0;
            ex_imm_q     <= 32'd0;
            ex_illegal_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd_q      <= ex_rd_d;
            ex_we_q      <= ex_we_d;
            ex_imm_q     <= ex_imm_d;
            ex_illegal_q <= ex_illegal_d;
        end
    end

    assign ex.ex_valid   = ex_valid_q;
    assign ex.ex_a       = ex_a_q;
    assign ex.ex_b       = ex_b_q;
    assign ex.ex_ctrl    = ex_ctrl_q;
    assign ex.ex_rd      = ex_rd_q;
    assign ex.ex_we      = ex_we_q;
    assign ex.ex_imm     = ex_imm_q;
    assign ex.ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: a small EX/WB/register-file environment around the
// DUT, an architectural reference model that executes instructions in
// program order, and a scoreboard checked whenever an entry leaves ID/EX.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        flush;
    logic        tb_init;

    id_stage_if exif();

    id_stage #(.NOP_OPC(4'h0)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_result(wb_result),
        .flush(flush), .ex(exif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: ALU, WB stage, register file ----------
    logic [31:0] rf [32];

    function automatic logic [31:0] rf_init(input int i);
        return 32'hC0DE_0000 + i * 32'h0001_0111;
    endfunction

    function automatic logic [31:0] env_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return a & b;
            3'b100:  return a | b;
            default: return 32'd0;
        endcase
    endfunction

    assign exif.alu_result = env_alu(exif.ex_ctrl, exif.ex_a, exif.ex_b);
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always @(posedge clk) begin
        wb_we     <= exif.ex_valid && exif.ex_ready && exif.ex_we;
        wb_rd     <= exif.ex_rd;
        wb_result <= exif.alu_result;
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (wb_we) begin
            rf[wb_rd] <= wb_result;
        end
    end

    // ---------------- reference model and scoreboard ---------------------
    typedef struct {
        logic [31:0] a, b, imm, res;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        pend;
    bit          pend_v;
    logic [31:0] mregs [32];
    bit          exp_ill;
    int          n_checks;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mval(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : mregs[r];
    endfunction

    // Architectural execution of one instruction; returns 0 if it issues nothing.
    function automatic bit model_exec(input logic [31:0] ins, output exp_t e, output bit illegal);
        logic [3:0]  opc;
        logic [31:0] x, y, s;
        opc = ins[31:28];
        x = mval(ins[22:18]);
        y = mval(ins[17:13]);
        s = {{19{ins[12]}}, ins[12:0]};
        e.a = x; e.b = y; e.imm = s; e.rd = ins[27:23]; e.we = (ins[27:23] != 5'd0);
        illegal = (opc >= 4'd7);
        case (opc)
            4'd1: begin e.ctrl = 3'b000; e.res = x + y; end
            4'd2: begin e.ctrl = 3'b001; e.res = x - y; end
            4'd3: begin e.ctrl = 3'b011; e.res = x & y; end
            4'd4: begin e.ctrl = 3'b100; e.res = x | y; end
            4'd5: begin e.ctrl = 3'b000; e.b = s; e.res = x + s; end
            4'd6: begin e.ctrl = 3'b010; e.we = 1'b0; e.res = 32'd0; end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One cycle: drive inputs after the edge, evaluate the handshake just before the next.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic fl, input logic r, output logic acc);
        exp_t e;
        bit   ill;
        @(posedge clk);
        #2;
        if_valid = v; if_instr = ins; exif.ex_ready = rdy; flush = fl; rst = r;
        #6;
        acc = 1'b0;
        exp_ill = 1'b0;
        if (rst) begin
            pend_v = 1'b0;
            exp_q.delete();
        end else if (flush) begin
            if (pend_v) begin
                pend_v = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_back());
            end
            acc = if_valid && if_ready;
        end else begin
            if (pend_v && exif.ex_ready) begin
                if (pend.we) mregs[pend.rd] = pend.res;
                pend_v = 1'b0;
            end
            acc = if_valid && if_ready;
            if (acc) begin
                if (model_exec(if_instr, e, ill)) begin
                    exp_q.push_back(e);
                    pend = e;
                    pend_v = 1'b1;
                end
                exp_ill = ill;
            end
        end
    endtask

    task automatic send(input logic [31:0] ins, input logic rdy, output int tries);
        logic acc;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 40) begin
            step(1'b1, ins, rdy, 1'b0, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: instr %h not accepted within 40 cycles", ins);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {opc, rd, rs1, rs2, imm};
    endfunction

    // ---------------- monitor ---------------------------------------------
    bit          rst_seen, held;
    logic [31:0] snap_a, snap_b, snap_imm;
    logic [9:0]  snap_misc;

    initial begin
        rst_seen = 1'b0;
        held = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_seen) begin
                chk("rst_ex_valid", {31'd0, exif.ex_valid}, 32'd0);
                chk("rst_ex_a", exif.ex_a, 32'd0);
                chk("rst_ex_b", exif.ex_b, 32'd0);
                chk("rst_ex_ctrl", {29'd0, exif.ex_ctrl}, 32'd0);
                chk("rst_ex_rd", {27'd0, exif.ex_rd}, 32'd0);
                chk("rst_ex_we", {31'd0, exif.ex_we}, 32'd0);
                chk("rst_ex_imm", exif.ex_imm, 32'd0);
                chk("rst_ex_illegal", {31'd0, exif.ex_illegal}, 32'd0);
            end else begin
                chk("ex_valid", {31'd0, exif.ex_valid}, {31'd0, exp_q.size() != 0});
                chk("ex_illegal", {31'd0, exif.ex_illegal}, {31'd0, exp_ill});
            end
            if (held) begin
                chk("hold_a", exif.ex_a, snap_a);
                chk("hold_b", exif.ex_b, snap_b);
                chk("hold_imm", exif.ex_imm, snap_imm);
                chk("hold_misc", {22'd0, exif.ex_valid, exif.ex_ctrl, exif.ex_rd, exif.ex_we},
                    {22'd0, snap_misc});
            end
            #8;
            rst_seen = rst;
            held = !rst && !flush && exif.ex_valid && !exif.ex_ready;
            snap_a = exif.ex_a; snap_b = exif.ex_b; snap_imm = exif.ex_imm;
            snap_misc = {exif.ex_valid, exif.ex_ctrl, exif.ex_rd, exif.ex_we};
            if (held) chk("if_ready_while_held", {31'd0, if_ready}, 32'd0);
            if (!rst && flush) chk("if_ready_on_flush", {31'd0, if_ready}, 32'd1);
            if (!rst && exif.ex_valid && exif.ex_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_issue: ex_a %h ex_b %h ctrl %b, none expected",
                             exif.ex_a, exif.ex_b, exif.ex_ctrl);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ex_a", exif.ex_a, e.a);
                    chk("ex_b", exif.ex_b, e.b);
                    chk("ex_ctrl", {29'd0, exif.ex_ctrl}, {29'd0, e.ctrl});
                    chk("ex_rd", {27'd0, exif.ex_rd}, {27'd0, e.rd});
                    chk("ex_we", {31'd0, exif.ex_we}, {31'd0, e.we});
                    chk("ex_imm", exif.ex_imm, e.imm);
                end
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        logic        acc;
        int          t;
        bit          have;
        logic [31:0] cur;
        logic [3:0]  opc;
        logic        rdy, fl, r;
        int          sel;

        n_checks = 0; n_err = 0;
        pend_v = 1'b0; exp_ill = 1'b0;
        rst = 1'b1; tb_init = 1'b1; if_valid = 1'b0; if_instr = 32'd0;
        exif.ex_ready = 1'b0; flush = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = rf_init(i);

        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        tb_init = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        chk("if_ready_after_reset", {31'd0, if_ready}, 32'd1);

        // ADD r3,r1,r2 with r1=5, r2=7; ADDI with all-ones immediate
        send(mk(4'd5, 5'd1, 5'd0, 5'd0, 13'd5), 1'b1, t);
        send(mk(4'd5, 5'd2, 5'd0, 5'd0, 13'd7), 1'b1, t);
        send(mk(4'd1, 5'd3, 5'd1, 5'd2, 13'd0), 1'b1, t);
        send(mk(4'd5, 5'd4, 5'd0, 5'd0, 13'h1FFF), 1'b1, t);

        // dependent pair: ADD r5 = 0x20, then SUB r6,r5,r5
        send(mk(4'd5, 5'd7, 5'd0, 5'd0, 13'h10), 1'b1, t);
        send(mk(4'd1, 5'd5, 5'd7, 5'd7, 13'd0), 1'b1, t);
        send(mk(4'd2, 5'd6, 5'd5, 5'd5, 13'd0), 1'b1, t);
`ifdef ID_FORWARD_EN
        chk("dep_no_bubble", t, 32'd1);
`else
        chk("dep_stalled", {31'd0, t > 1}, 32'd1);
`endif

        // BLT held for three cycles, then released
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        send(mk(4'd6, 5'd9, 5'd1, 5'd2, 13'h0040), 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, mk(4'd4, 5'd8, 5'd1, 5'd2, 13'd0), 1'b0, 1'b0, 1'b0, acc);
            chk("blt_held_no_accept", {31'd0, acc}, 32'd0);
        end
        step(1'b1, mk(4'd4, 5'd8, 5'd1, 5'd2, 13'd0), 1'b1, 1'b0, 1'b0, acc);
        chk("blt_release_accept", {31'd0, acc}, 32'd1);

        // OR now held in ID/EX; flush kills it and the incoming AND
        step(1'b1, mk(4'd3, 5'd10, 5'd1, 5'd2, 13'd0), 1'b0, 1'b1, 1'b0, acc);
        chk("flush_consumes", {31'd0, acc}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

        // illegal opcode, then reset with an entry in flight
        send(mk(4'hF, 5'd3, 5'd1, 5'd2, 13'h0123), 1'b1, t);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        send(mk(4'd1, 5'd11, 5'd1, 5'd2, 13'd0), 1'b0, t);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

        // randomized traffic
        have = 1'b0;
        cur = 32'd0;
        for (int c = 0; c < 2000; c++) begin
            if (!have && $urandom_range(0, 9) < 8) begin
                sel = $urandom_range(0, 19);
                if (sel < 17) opc = 4'($urandom_range(1, 6));
                else if (sel == 17) opc = 4'd0;
                else opc = 4'($urandom_range(7, 15));
                cur = mk(opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 13'($urandom));
                have = 1'b1;
            end
            r   = ($urandom_range(0, 299) == 0);
            rdy = !r && ($urandom_range(0, 9) < 7);
            fl  = !r && !rdy && ($urandom_range(0, 19) == 0);
            step(have, cur, rdy, fl, r, acc);
            if (acc || r) have = 1'b0;
        end

        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/issue stage of the in-order pipeline, feeding the execution-stage ALU. Accepts one 32-bit instruction per cycle from fetch, reads two register-file ports, resolves operand hazards, and produces the registered ALU operands, the 3-bit ALU control code, and writeback tags in an ID/EX pipeline register with a valid/ready handshake. It is the producer side of the ALU control interface.

## Interface
Parameters:
- `NOP_OPC` = 4'h0: opcode treated as a bubble (accepted, not issued).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch holds an instruction.
- `if_instr`  in  32  instruction: [31:28] opc, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm.
- `if_ready`  out  1  stage accepts `if_instr` this cycle.
- `rf_raddr1`, `rf_raddr2`  out  5  combinational = `if_instr[22:18]`, `if_instr[17:13]`.
- `rf_rdata1`, `rf_rdata2`  in  32  same-cycle read data (read-old on same-cycle write).
- `alu_result`  in  32  combinational ALU result of the current ID/EX entry.
- `wb_we`, `wb_rd`, `wb_result`  in  1/5/32  entry being written to the register file this cycle.
- `flush`  in  1  taken branch resolved; kill ID/EX entry and incoming instruction.
- `ex_ready`  in  1  execution stage accepts the ID/EX entry.
- `ex_valid`  out  1  ID/EX entry valid.
- `ex_a`, `ex_b`  out  32  ALU operands.
- `ex_ctrl`  out  3  ALU control.
- `ex_rd`  out  5; `ex_we`  out  1; `ex_imm`  out  32 (sign-extended imm, branch offset).
- `ex_illegal`  out  1  one-cycle pulse: an illegal opcode was accepted.

## Operation
- Decode (opc → ctrl, B source, we): 1 ADD → 000, rs2, 1; 2 SUB → 001, rs2, 1; 3 AND → 011, rs2, 1; 4 OR → 100, rs2, 1; 5 ADDI → 000, sext(imm), 1; 6 BLT → 010, rs2, 0. `NOP_OPC` and opcodes 7–15 issue nothing; 7–15 additionally pulse `ex_illegal`.
- `ex_we` forced 0 when rd = 0; reads of r0 return 0 regardless of `rf_rdata`/forwarding.
- Accept = `if_valid && if_ready`. Advance = `!ex_valid || ex_ready`.
- Hazard on source s (s ≠ 0, s used): EX-hit if `ex_valid && ex_we && ex_rd == s`; WB-hit if `wb_we && wb_rd == s`. EX-hit has priority over WB-hit.
- Operand select (forwarding on): EX-hit → `alu_result`; else WB-hit → `wb_result`; else `rf_rdata`. EX-hit forwarding used only when the entry advances in the same cycle (`ex_ready`=1).
- `if_ready` = Advance && !stall, or `flush`. stall: see Configuration.
- ID/EX register update priority: `rst` > `flush` (ex_valid←0, incoming dropped) > Accept of issuing op (load, ex_valid←1) > Advance (ex_valid←0) > hold.
- Held entry keeps all `ex_*` stable while `ex_valid && !ex_ready`.

## Timing
- Reset: `ex_valid`, `ex_a`, `ex_b`, `ex_ctrl`, `ex_rd`, `ex_we`, `ex_imm`, `ex_illegal` all 0; `if_ready` = 1 after reset when no flush/stall.
- Latency: instruction accepted at cycle N appears on `ex_*` with `ex_valid`=1 at N+1.
- Throughput: 1/cycle with `ex_ready` held high and no stalls.
- `rf_raddr*` are combinational from `if_instr`; no registered address path.
- `flush` and Accept same cycle: instruction consumed and discarded; `ex_valid`=0 next cycle.
- `ex_illegal` registered: high at N+1 for one cycle, `ex_valid`=0.

## Configuration
- `ID_FORWARD_EN` defined: forwarding per Operation; stall = EX-hit && !`ex_ready` only.
- Undefined: no forwarding paths; stall = any EX-hit or WB-hit; operands always `rf_rdata`. Instruction held on `if_instr` until hazard clears.

## Test plan
- Reset then ADD r3,r1,r2 with rf r1=5, r2=7 → next cycle `ex_valid`=1, `ex_a`=5, `ex_b`=7, `ex_ctrl`=000, `ex_rd`=3, `ex_we`=1.
- ADDI r4,r0,imm=0x1FFF → `ex_a`=0, `ex_b`=0xFFFFFFFF, `ex_imm`=0xFFFFFFFF, `ex_ctrl`=000.
- ADD r5,.. (alu_result=0x20) followed by SUB r6,r5,r5 → with `ID_FORWARD_EN`: `ex_a`=`ex_b`=0x20, no bubble; without: `if_ready`=0 until EX and WB hits clear, then operands from rf.
- BLT r1,r2 while `ex_ready`=0 for 3 cycles → `ex_*` stable, `if_ready`=0, `ex_ctrl`=010, `ex_we`=0; released on `ex_ready`=1.
- `flush` asserted with valid OR instruction at input and valid entry held → next cycle `ex_valid`=0, OR never issued.
- Opcode 0xF accepted → `ex_illegal`=1 one cycle, `ex_valid`=0; `rst` mid-stream → all outputs 0 next cycle.
